// File: rtl/quadrilatero_skewer.sv
// Skews unskewed matrix rows into a diagonal wavefront for a systolic mesh.
// Lane i is delayed by i steps; a tile's last row triggers a zero-filled drain.
module quadrilatero_skewer #(
    parameter int unsigned MESH_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   clear_i,
    input  logic                                   valid_i,
    input  logic                                   last_i,
    output logic                                   ready_o,
    input  logic [MESH_WIDTH-1:0][DATA_WIDTH-1:0]  data_i,
    input  logic                                   mesh_ready_i,
    output logic                                   valid_o,
    output logic [MESH_WIDTH-1:0][DATA_WIDTH-1:0]  data_o,
    output logic [MESH_WIDTH-1:0]                  lane_valid_o,
    output logic                                   busy_o
);

    localparam int unsigned DCW = $clog2(MESH_WIDTH) + 1;
    localparam logic [DCW-1:0] DRAIN_LAST =
        DCW'((MESH_WIDTH > 1) ? (MESH_WIDTH - 2) : 0);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_e;

    state_e         state_q, state_d;
    logic [DCW-1:0] cnt_q, cnt_d;
    logic           fire;
    logic           step;

    assign ready_o = mesh_ready_i & (state_q != DRAIN);
    assign fire    = valid_i & ready_o;
    assign step    = fire | ((state_q == DRAIN) & mesh_ready_i);
    assign valid_o = step;
    assign busy_o  = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, STREAM: begin
                if (fire) begin
                    if (!last_i) begin
                        state_d = STREAM;
                    end else if (MESH_WIDTH == 1) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DRAIN;
                        cnt_d   = '0;
                    end
                end
            end
            DRAIN: begin
                if (mesh_ready_i) begin
                    if (cnt_q == DRAIN_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + DCW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (clear_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Lane 0 is a pure pass-through of the accepted row.
    assign data_o[0]       = fire ? data_i[0] : '0;
    assign lane_valid_o[0] = fire;

    for (genvar i = 1; i < MESH_WIDTH; i++) begin : g_lane
        logic [i-1:0][DATA_WIDTH-1:0] d_q;
        logic [i-1:0]                 v_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                d_q <= '0;
                v_q <= '0;
            end else if (clear_i) begin
                d_q <= '0;
                v_q <= '0;
            end else if (step) begin
                for (int k = i - 1; k >= 1; k--) begin
                    d_q[k] <= d_q[k-1];
                    v_q[k] <= v_q[k-1];
                end
                d_q[0] <= fire ? data_i[i] : '0;
                v_q[0] <= fire;
            end
        end

        assign data_o[i]       = step ? d_q[i-1] : '0;
        assign lane_valid_o[i] = step & v_q[i-1];
    end

endmodule
